ems_sdram_bridge: RTL and testbench
===================================

# ems_sdram_bridge

Wishbone-slave-to-SDRAM request bridge for the conventional/UMB memory window. Sits between the CPU data bus and the SDRAM controller, directly downstream of the EMS page translator. It registers each 16-bit access and presents its address to the translator. It then captures the translated address and runs a req/grant/read-valid handshake with the SDRAM controller, with a read-timeout watchdog.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed in WAIT_RD before abort; legal 1..255.
- `wb_clk`  in  1  clock; all logic on rising edge.
- `wb_rst_n`  in  1  asynchronous, active-low reset.
- `wb_adr_i`  in  19 [19:1]  word address.
- `wb_dat_i`  in  16  write data.
- `wb_dat_o`  out  16  read data, registered.
- `wb_sel_i`  in  2  byte lanes.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1  Wishbone classic controls.
- `wb_ack_o`  out  1  registered one-cycle acknowledge.
- `ems_adr_o`  out  19 [19:1]  registered address to translator.
- `ems_adr_i`  in  32  translated address from translator; word index in bits [23:2]; [31:24] and [1:0] ignored.
- `sdram_req_o`  out  1  request.
- `sdram_we_o`  out  1  write.
- `sdram_adr_o`  out  22  word address = captured `ems_adr_i[23:2]`.
- `sdram_be_o`  out  2  byte enables = captured `wb_sel_i`.
- `sdram_dat_o`  out  16  write data.
- `sdram_gnt_i`  in  1  controller accepted request this cycle.
- `sdram_rdv_i`  in  1  read data valid.
- `sdram_dat_i`  in  16  read data.
- `timeout_o`  out  1  sticky read-timeout flag.

## Operation
- States: IDLE, XLATE, REQ, WAIT_RD, ACK.
- IDLE: when `wb_cyc_i & wb_stb_i`, capture the following and go to XLATE:
  - `wb_adr_i` into `ems_adr_o`;
  - `wb_we_i`, `wb_sel_i` and `wb_dat_i` into the SDRAM-side registers.
- XLATE: latch `ems_adr_i[23:2]` into `sdram_adr_o`.
  - Captured sel = 00: go to ACK. No SDRAM request is made, and `wb_dat_o` is unchanged.
  - Otherwise: go to REQ.
- REQ: `sdram_req_o`=1 and held, with address, we, be and data stable, until `sdram_gnt_i` is sampled high.
  - On grant with write: go to ACK.
  - On grant with read: clear the timeout counter and go to WAIT_RD.
- WAIT_RD: counter increments each cycle.
  - `sdram_rdv_i`=1: latch `sdram_dat_i` into `wb_dat_o`, go to ACK.
  - Else if counter == `TIMEOUT_CYCLES`-1: `wb_dat_o`=16'hFFFF, set `timeout_o`, go to ACK.
  - rdv and timeout in the same cycle: rdv wins, and `timeout_o` is not set.
- ACK: `wb_ack_o` = `wb_cyc_i` for exactly one cycle, then go to IDLE.
- A new access can be captured in the cycle after ack, so back-to-back operation is supported.
- `sdram_rdv_i` outside WAIT_RD is ignored; this covers late data after a timeout.
- `wb_cyc_i` dropping mid-transaction does not retract the transaction:
  - `sdram_req_o` is never deasserted before grant;
  - the transaction completes on the SDRAM side;
  - ack is suppressed.
- `timeout_o` clears only on reset.

## Timing
- Reset (async, immediate), all outputs 0:
  - `wb_ack_o`, `sdram_req_o`, `sdram_we_o`, `timeout_o`;
  - `wb_dat_o`, `ems_adr_o`, `sdram_adr_o`, `sdram_be_o`, `sdram_dat_o`.
- Reset mid-transaction aborts at once; state returns to IDLE and `sdram_req_o` drops.
- Cycle numbering: stb first sampled at edge 0, so state is XLATE in cycle 1 and REQ in cycle 2.
- `sdram_req_o` high from cycle 2.
- Write with grant in cycle 2: ack in cycle 3.
- Read with grant in cycle 2 and rdv in cycle k (k≥3): ack and data in cycle k+1.
- Read, no rdv, grant in cycle 2: ack in cycle 3+`TIMEOUT_CYCLES`.
- sel = 00: ack in cycle 2.
- Counter is 8 bits and never wraps; the compare forces exit first.

## Test plan
- Write: adr 19'h12345, dat 16'hBEEF, sel 11, `ems_adr_i`=32'h0048D14.
  - Required: `sdram_adr_o`=22'h012345, we=1, be=11, dat BEEF.
  - Grant in cycle 2 gives ack in cycle 3, lasting exactly one cycle.
- Read, grant delayed 4 cycles, rdv 2 cycles after grant with 16'hA5C3:
  - `sdram_req_o` held through the wait;
  - `wb_dat_o`=A5C3 with ack in the cycle after rdv.
- Read timeout, `TIMEOUT_CYCLES`=4, no rdv:
  - `wb_dat_o`=FFFF and `timeout_o`=1 with ack.
  - A late rdv in IDLE is ignored.
  - A following read with rdv returns data, and `timeout_o` stays 1.
- Read with rdv in the same cycle as the timeout compare: data returned, `timeout_o` stays 0.
- sel=00 access: no `sdram_req_o`, ack in cycle 2, `wb_dat_o` unchanged.
- Back-to-back writes with stb held high: second capture the cycle after first ack.
- `wb_rst_n` pulsed low while in REQ: `sdram_req_o` drops asynchronously and all outputs are 0.

Source files
------------

// File: rtl/ems_sdram_bridge.sv
// rtl/ems_sdram_bridge.sv - Wishbone slave to SDRAM request bridge with EMS translation stage and read watchdog
module ems_sdram_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [19:1] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [19:1] ems_adr_o,
  input  logic [31:0] ems_adr_i,
  output logic        sdram_req_o,
  output logic        sdram_we_o,
  output logic [21:0] sdram_adr_o,
  output logic [1:0]  sdram_be_o,
  output logic [15:0] sdram_dat_o,
  input  logic        sdram_gnt_i,
  input  logic        sdram_rdv_i,
  input  logic [15:0] sdram_dat_i,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_XLATE   = 3'd1,
    S_REQ     = 3'd2,
    S_WAIT_RD = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  // Last counter value before the watchdog gives up on read data.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [19:1] r_ems_adr;
  logic        r_we;
  logic [1:0]  r_sel;
  logic [15:0] r_wdat;
  logic [21:0] r_sdram_adr;
  logic [15:0] r_rdat;
  logic        r_timeout;
  logic [7:0]  r_cnt;

  logic        w_capture;
  logic        w_latch_adr;
  logic        w_cnt_clr;
  logic        w_rd_data;
  logic        w_rd_timeout;

  // Translator page bits and byte offset bits carry no meaning for a word access.
  logic        w_unused_adr_bits;
  assign w_unused_adr_bits = &{1'b0, ems_adr_i[31:24], ems_adr_i[1:0]};

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_latch_adr  = 1'b0;
    w_cnt_clr    = 1'b0;
    w_rd_data    = 1'b0;
    w_rd_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_XLATE;
        end
      end
      S_XLATE: begin
        w_latch_adr = 1'b1;
        // No byte lanes selected: nothing to move, complete without touching SDRAM.
        w_state_nxt = (r_sel == 2'b00) ? S_ACK : S_REQ;
      end
      S_REQ: begin
        if (sdram_gnt_i) begin
          if (r_we) begin
            w_state_nxt = S_ACK;
          end else begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_WAIT_RD;
          end
        end
      end
      S_WAIT_RD: begin
        // Read data beats the watchdog when both land in the same cycle.
        if (sdram_rdv_i) begin
          w_rd_data   = 1'b1;
          w_state_nxt = S_ACK;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_rd_timeout = 1'b1;
          w_state_nxt  = S_ACK;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Access capture, translated address latch, read data and sticky timeout flag.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ems_adr   <= '0;
      r_we        <= 1'b0;
      r_sel       <= 2'b00;
      r_wdat      <= '0;
      r_sdram_adr <= '0;
      r_rdat      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_ems_adr <= wb_adr_i;
        r_we      <= wb_we_i;
        r_sel     <= wb_sel_i;
        r_wdat    <= wb_dat_i;
      end
      if (w_latch_adr) begin
        r_sdram_adr <= ems_adr_i[23:2];
      end
      if (w_rd_data) begin
        r_rdat <= sdram_dat_i;
      end else if (w_rd_timeout) begin
        r_rdat <= 16'hFFFF;
      end
      if (w_rd_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Read watchdog counter; the terminal compare exits WAIT_RD before it could wrap.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT_RD) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign wb_ack_o    = (r_state == S_ACK) && wb_cyc_i;
  assign wb_dat_o    = r_rdat;
  assign ems_adr_o   = r_ems_adr;
  assign sdram_req_o = (r_state == S_REQ);
  assign sdram_we_o  = r_we;
  assign sdram_adr_o = r_sdram_adr;
  assign sdram_be_o  = r_sel;
  assign sdram_dat_o = r_wdat;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_ems_sdram_bridge.sv
// tb/tb_ems_sdram_bridge.sv - self-checking bench for ems_sdram_bridge
module tb_ems_sdram_bridge;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:1] adr = '0;
  logic [15:0] dati = '0;
  logic [15:0] dato;
  logic [1:0]  sel = 2'b00;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        ack;
  logic [19:1] ems_adr_o;
  logic [31:0] ems_adr_i;
  logic        sdram_req;
  logic        sdram_we;
  logic [21:0] sdram_adr;
  logic [1:0]  sdram_be;
  logic [15:0] sdram_dout;
  logic        gnt = 1'b0;
  logic        rdv = 1'b0;
  logic [15:0] sdram_din = '0;
  logic        timeout;

  // Translator model: word offset plus junk in the ignored bit ranges.
  logic [21:0] tb_off = '0;
  logic [7:0]  tb_hi = '0;
  logic [1:0]  tb_lo = '0;
  assign ems_adr_i = {tb_hi, 22'({3'b000, ems_adr_o}) + tb_off, tb_lo};

  int tests = 0;
  int failed = 0;
  logic [15:0] m_dout = '0;
  logic        m_to = 1'b0;

  ems_sdram_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(dati), .wb_dat_o(dato),
    .wb_sel_i(sel), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_ack_o(ack),
    .ems_adr_o(ems_adr_o), .ems_adr_i(ems_adr_i), .sdram_req_o(sdram_req),
    .sdram_we_o(sdram_we), .sdram_adr_o(sdram_adr), .sdram_be_o(sdram_be),
    .sdram_dat_o(sdram_dout), .sdram_gnt_i(gnt), .sdram_rdv_i(rdv),
    .sdram_dat_i(sdram_din), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:1] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        we;
    int          g;
    int          d;
    logic [15:0] rd;
    bit          hold;
    int          exp_ack;
    logic [15:0] exp_dout;
    bit          exp_to;
  } vec_t;

  vec_t vecs[9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access: stb sampled at the next edge (edge 0); n counts cycles after it.
  task automatic run_txn(input logic [19:1] a, input logic [15:0] d, input logic [1:0] s,
                         input logic w, input int g, input int dly, input logic [15:0] rd,
                         input bit hold, input int exp_ack, input logic [15:0] exp_dout,
                         input bit exp_to);
    int n;
    int ack_n;
    bit req_bad;
    bit exp_req;
    logic [21:0] exp_adr;
    exp_adr = 22'({3'b000, a}) + tb_off;
    cyc = 1'b1; stb = 1'b1; adr = a; dati = d; sel = s; we = w; gnt = 1'b0; rdv = 1'b0;
    n = 0; ack_n = -1; req_bad = 1'b0;
    while (ack_n < 0 && n < 400) begin
      tick;
      n++;
      gnt = (n == 2 + g);
      rdv = (dly != 0) && (n == 2 + g + dly);
      sdram_din = rdv ? rd : 16'h5555;
      if (n == 1) chk("ems_adr", 64'(ems_adr_o), 64'(a));
      exp_req = (s != 2'b00) && (n >= 2) && (n <= 2 + g);
      if (sdram_req !== exp_req) req_bad = 1'b1;
      if (n == 2 + g && s != 2'b00)
        chk("sdram_fields", {23'd0, sdram_adr, sdram_we, sdram_be, sdram_dout},
            {23'd0, exp_adr, w, s, d});
      if (ack) ack_n = n;
    end
    chk("req_window", 64'(req_bad), 64'd0);
    chk("ack_cycle", 64'(ack_n), 64'(exp_ack));
    chk("rd_data", 64'(dato), 64'(exp_dout));
    chk("timeout", 64'(timeout), 64'(exp_to));
    if (!hold) begin
      cyc = 1'b0; stb = 1'b0;
    end
    gnt = 1'b0; rdv = 1'b0;
    tick;
    chk("ack_one_cycle", 64'(ack), 64'd0);
    if (!hold) begin
      rdv = 1'b1; sdram_din = 16'hDEAD;
      tick;
      rdv = 1'b0;
      chk("idle_rdv_ignored", {46'd0, dato, ack, sdram_req}, {46'd0, exp_dout, 2'b00});
    end
  endtask

  initial begin
    int g, dly, exp_ack;
    logic [1:0] s;
    logic w;
    logic [15:0] rd;
    logic [19:1] a;

    vecs[0] = '{19'h12345, 16'hBEEF, 2'b11, 1'b1, 0, 0, 16'h0000, 1'b0, 3, 16'h0000, 1'b0};
    vecs[1] = '{19'h00ABC, 16'h0000, 2'b11, 1'b0, 4, 2, 16'hA5C3, 1'b0, 9, 16'hA5C3, 1'b0};
    vecs[2] = '{19'h7FFFF, 16'h0000, 2'b10, 1'b0, 0, 4, 16'h1234, 1'b0, 7, 16'h1234, 1'b0};
    vecs[3] = '{19'h00001, 16'h0000, 2'b00, 1'b0, 0, 1, 16'h9999, 1'b0, 2, 16'h1234, 1'b0};
    vecs[4] = '{19'h40000, 16'h0000, 2'b01, 1'b0, 0, 0, 16'h0000, 1'b0, 7, 16'hFFFF, 1'b1};
    vecs[5] = '{19'h00002, 16'h0000, 2'b11, 1'b0, 1, 1, 16'h0F0F, 1'b0, 5, 16'h0F0F, 1'b1};
    vecs[6] = '{19'h11111, 16'hCAFE, 2'b11, 1'b1, 0, 0, 16'h0000, 1'b1, 3, 16'h0F0F, 1'b1};
    vecs[7] = '{19'h22222, 16'hF00D, 2'b01, 1'b1, 2, 0, 16'h0000, 1'b1, 5, 16'h0F0F, 1'b1};
    vecs[8] = '{19'h00003, 16'h0000, 2'b11, 1'b0, 0, 5, 16'h7777, 1'b0, 7, 16'hFFFF, 1'b1};

    #3;
    chk("reset_ctrl", {60'd0, ack, sdram_req, sdram_we, timeout}, 64'd0);
    chk("reset_data", {9'd0, dato, ems_adr_o, sdram_be, sdram_dout}, 64'd0);
    chk("reset_sdram_adr", 64'(sdram_adr), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we, vecs[i].g, vecs[i].d,
              vecs[i].rd, vecs[i].hold, vecs[i].exp_ack, vecs[i].exp_dout, vecs[i].exp_to);
      m_dout = vecs[i].exp_dout;
      m_to = vecs[i].exp_to;
    end

    // Master abandons the cycle: request still runs to grant, ack never shows.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 19'h05555; dati = 16'h1111;
    tick;
    cyc = 1'b0; stb = 1'b0;
    tick;
    chk("drop_req_c2", 64'(sdram_req), 64'd1);
    tick;
    chk("drop_req_c3", 64'(sdram_req), 64'd1);
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    chk("drop_no_ack", {62'd0, ack, sdram_req}, 64'd0);
    tick;
    tick;

    // Random accesses checked against transaction-level expectations.
    for (int i = 0; i < 40; i++) begin
      tb_off = 22'($urandom);
      tb_hi = 8'($urandom);
      tb_lo = 2'($urandom);
      a = 19'($urandom);
      s = 2'($urandom);
      w = 1'($urandom);
      g = $urandom_range(0, 5);
      dly = $urandom_range(0, 7);
      rd = 16'($urandom);
      if (s == 2'b00) begin
        exp_ack = 2;
      end else if (w) begin
        exp_ack = 3 + g;
      end else if (dly != 0 && dly <= T) begin
        exp_ack = 3 + g + dly;
        m_dout = rd;
      end else begin
        exp_ack = 3 + g + T;
        m_dout = 16'hFFFF;
        m_to = 1'b1;
      end
      run_txn(a, 16'($urandom), s, w, g, dly, rd, 1'b0, exp_ack, m_dout, m_to);
    end

    // Reset asserted while a request is waiting for grant.
    tb_off = '0; tb_hi = '0; tb_lo = '0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 19'h3ABCD; dati = 16'h4321;
    tick;
    tick;
    tick;
    chk("req_before_reset", 64'(sdram_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", {60'd0, ack, sdram_req, sdram_we, timeout}, 64'd0);
    chk("async_reset_data", {9'd0, dato, ems_adr_o, sdram_be, sdram_dout}, 64'd0);
    chk("async_reset_sdram_adr", 64'(sdram_adr), 64'd0);
    cyc = 1'b0; stb = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    run_txn(19'h00404, 16'h0000, 2'b11, 1'b0, 0, 1, 16'h1357, 1'b0, 4, 16'h1357, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
